// File: rtl/mcpu_core_scoreboard.sv
// mcpu_core_scoreboard
//   Tracks in-flight GPR and predicate writes between decode issue and
//   writeback retire, and runs a drain handshake used by fence/eret/mtc.
//
// Ports
//   clkrst_core_clk       : clock, all state changes on its rising edge
//   clkrst_core_rst       : synchronous active-high reset
//   issue_valid           : decode bundle issues this cycle
//   issue_rd_we/_rd_num   : per-lane GPR destination at issue (5 bits/lane)
//   issue_pred_we/_num    : per-lane predicate destination at issue (2 bits/lane)
//   wb_rd_we/_rd_num      : per-lane GPR retire at writeback
//   wb_pred_we/_num       : per-lane predicate retire at writeback
//   pipe_flush            : squash all in-flight writes
//   drain_req             : wait until no writes are pending
//   sb2d_reg_scoreboard   : pending GPR write bits
//   sb2d_pred_scoreboard  : pending predicate write bits p0..p2
//   sb_hold               : blocks decode issue while draining
//   drain_ack             : one-cycle drain-complete pulse
//   sb_pending_cnt        : number of set scoreboard bits (0..35)
//   sb_conflict           : one-cycle pulse on an illegal issue/writeback
module mcpu_core_scoreboard #(
    parameter int unsigned NLANES = 4
) (
    input  logic                  clkrst_core_clk,
    input  logic                  clkrst_core_rst,
    input  logic                  issue_valid,
    input  logic [NLANES-1:0]     issue_rd_we,
    input  logic [5*NLANES-1:0]   issue_rd_num,
    input  logic [NLANES-1:0]     issue_pred_we,
    input  logic [2*NLANES-1:0]   issue_pred_num,
    input  logic [NLANES-1:0]     wb_rd_we,
    input  logic [5*NLANES-1:0]   wb_rd_num,
    input  logic [NLANES-1:0]     wb_pred_we,
    input  logic [2*NLANES-1:0]   wb_pred_num,
    input  logic                  pipe_flush,
    input  logic                  drain_req,
    output logic [31:0]           sb2d_reg_scoreboard,
    output logic [2:0]            sb2d_pred_scoreboard,
    output logic                  sb_hold,
    output logic                  drain_ack,
    output logic [5:0]            sb_pending_cnt,
    output logic                  sb_conflict
);

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_ACK
    } drain_t;

    drain_t      state_q;
    drain_t      state_nxt;

    logic        issue_en;
    logic [31:0] reg_set;
    logic [31:0] reg_clr;
    logic [2:0]  pred_set;
    logic [2:0]  pred_clr;
    logic        dup_issue;
    logic        bad_retire;
    logic [4:0]  rd_i;
    logic [1:0]  pn_i;
    logic [31:0] reg_nxt;
    logic [2:0]  pred_nxt;
    logic        conflict_nxt;
    logic [5:0]  cnt_nxt;
    logic        all_clear;

    // Set/clear masks and conflict detection across all lanes.
    always_comb begin
        reg_set    = '0;
        reg_clr    = '0;
        pred_set   = '0;
        pred_clr   = '0;
        dup_issue  = 1'b0;
        bad_retire = 1'b0;
        rd_i       = '0;
        pn_i       = '0;
        issue_en   = issue_valid & ~sb_hold;

        for (int unsigned i = 0; i < NLANES; i++) begin
            rd_i = issue_rd_num[5*i +: 5];
            if (issue_en && issue_rd_we[i]) begin
                if (reg_set[rd_i]) dup_issue = 1'b1;
                reg_set[rd_i] = 1'b1;
            end

            pn_i = issue_pred_num[2*i +: 2];
            for (int unsigned j = 0; j < 3; j++) begin
                if (issue_en && issue_pred_we[i] && pn_i == j[1:0]) begin
                    if (pred_set[j]) dup_issue = 1'b1;
                    pred_set[j] = 1'b1;
                end
            end

            // Retiring a bit that is not pending is flagged against the
            // registered state, before this cycle's issues are applied.
            rd_i = wb_rd_num[5*i +: 5];
            if (wb_rd_we[i]) begin
                if (!sb2d_reg_scoreboard[rd_i]) bad_retire = 1'b1;
                reg_clr[rd_i] = 1'b1;
            end

            pn_i = wb_pred_num[2*i +: 2];
            for (int unsigned j = 0; j < 3; j++) begin
                if (wb_pred_we[i] && pn_i == j[1:0]) begin
                    if (!sb2d_pred_scoreboard[j]) bad_retire = 1'b1;
                    pred_clr[j] = 1'b1;
                end
            end
        end
    end

    // Next-state bits: set wins over a same-cycle retire; flush overrides all.
    always_comb begin
        reg_nxt      = '0;
        pred_nxt     = '0;
        conflict_nxt = 1'b0;
        cnt_nxt      = '0;
        if (!pipe_flush) begin
            reg_nxt      = (sb2d_reg_scoreboard & ~reg_clr) | reg_set;
            pred_nxt     = (sb2d_pred_scoreboard & ~pred_clr) | pred_set;
            conflict_nxt = dup_issue | bad_retire;
        end
        for (int unsigned k = 0; k < 32; k++) begin
            cnt_nxt = cnt_nxt + {5'd0, reg_nxt[k]};
        end
        for (int unsigned k = 0; k < 3; k++) begin
            cnt_nxt = cnt_nxt + {5'd0, pred_nxt[k]};
        end
    end

    assign all_clear = (sb2d_reg_scoreboard == '0) && (sb2d_pred_scoreboard == '0);

    // Drain FSM next state; a dropped request abandons the drain even if
    // the scoreboard happens to be empty in the same cycle.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            DR_IDLE: if (drain_req) state_nxt = DR_WAIT;
            DR_WAIT: begin
                if (!drain_req)     state_nxt = DR_IDLE;
                else if (all_clear) state_nxt = DR_ACK;
            end
            DR_ACK:  state_nxt = DR_IDLE;
            default: state_nxt = DR_IDLE;
        endcase
    end

    // hold/ack are registered copies of the next-state decode so they line
    // up with the state register.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_q              <= DR_IDLE;
            sb2d_reg_scoreboard  <= '0;
            sb2d_pred_scoreboard <= '0;
            sb_pending_cnt       <= '0;
            sb_conflict          <= 1'b0;
            sb_hold              <= 1'b0;
            drain_ack            <= 1'b0;
        end else begin
            state_q              <= state_nxt;
            sb2d_reg_scoreboard  <= reg_nxt;
            sb2d_pred_scoreboard <= pred_nxt;
            sb_pending_cnt       <= cnt_nxt;
            sb_conflict          <= conflict_nxt;
            sb_hold              <= (state_nxt != DR_IDLE);
            drain_ack            <= (state_nxt == DR_ACK);
        end
    end

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Testbench for mcpu_core_scoreboard: directed scenarios followed by random
// traffic. A driver pushes the reference model's expected outputs into a
// queue; a monitor pops and compares after every rising edge.
module tb_mcpu_core_scoreboard;

    localparam int NL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [NL-1:0]   issue_rd_we;
    logic [5*NL-1:0] issue_rd_num;
    logic [NL-1:0]   issue_pred_we;
    logic [2*NL-1:0] issue_pred_num;
    logic [NL-1:0]   wb_rd_we;
    logic [5*NL-1:0] wb_rd_num;
    logic [NL-1:0]   wb_pred_we;
    logic [2*NL-1:0] wb_pred_num;
    logic            pipe_flush;
    logic            drain_req;
    logic [31:0]     reg_sb;
    logic [2:0]      pred_sb;
    logic            sb_hold;
    logic            drain_ack;
    logic [5:0]      cnt;
    logic            conflict;

    always #5 clk = ~clk;

    mcpu_core_scoreboard #(.NLANES(NL)) dut (
        .clkrst_core_clk      (clk),
        .clkrst_core_rst      (rst),
        .issue_valid          (issue_valid),
        .issue_rd_we          (issue_rd_we),
        .issue_rd_num         (issue_rd_num),
        .issue_pred_we        (issue_pred_we),
        .issue_pred_num       (issue_pred_num),
        .wb_rd_we             (wb_rd_we),
        .wb_rd_num            (wb_rd_num),
        .wb_pred_we           (wb_pred_we),
        .wb_pred_num          (wb_pred_num),
        .pipe_flush           (pipe_flush),
        .drain_req            (drain_req),
        .sb2d_reg_scoreboard  (reg_sb),
        .sb2d_pred_scoreboard (pred_sb),
        .sb_hold              (sb_hold),
        .drain_ack            (drain_ack),
        .sb_pending_cnt       (cnt),
        .sb_conflict          (conflict)
    );

    typedef struct {
        logic [31:0] r;
        logic [2:0]  p;
        logic        hold;
        logic        ack;
        logic        conf;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: pending flags per register/predicate and a drain
    // phase (0 = not draining, 1 = waiting for empty, 2 = acknowledging).
    bit   m_r[32];
    bit   m_p[3];
    int   phase = 0;

    task automatic model_step();
        bit   nr[32];
        bit   np[3];
        int   hits_r[32];
        int   hits_p[3];
        bit   conf;
        bit   empty;
        bit   may_issue;
        int   num;
        exp_t e;
        conf = 0;
        if (rst) begin
            foreach (m_r[k]) m_r[k] = 0;
            foreach (m_p[k]) m_p[k] = 0;
            phase = 0;
        end else begin
            empty = 1;
            foreach (m_r[k]) if (m_r[k]) empty = 0;
            foreach (m_p[k]) if (m_p[k]) empty = 0;
            nr = m_r;
            np = m_p;
            if (pipe_flush) begin
                foreach (nr[k]) nr[k] = 0;
                foreach (np[k]) np[k] = 0;
            end else begin
                foreach (hits_r[k]) hits_r[k] = 0;
                foreach (hits_p[k]) hits_p[k] = 0;
                may_issue = issue_valid && (phase == 0);
                for (int l = 0; l < NL; l++) begin
                    if (may_issue && issue_rd_we[l]) begin
                        num = int'(issue_rd_num[l*5 +: 5]);
                        hits_r[num]++;
                    end
                    if (may_issue && issue_pred_we[l]) begin
                        num = int'(issue_pred_num[l*2 +: 2]);
                        if (num < 3) hits_p[num]++;
                    end
                    if (wb_rd_we[l]) begin
                        num = int'(wb_rd_num[l*5 +: 5]);
                        if (!m_r[num]) conf = 1;
                        nr[num] = 0;
                    end
                    if (wb_pred_we[l]) begin
                        num = int'(wb_pred_num[l*2 +: 2]);
                        if (num < 3) begin
                            if (!m_p[num]) conf = 1;
                            np[num] = 0;
                        end
                    end
                end
                foreach (hits_r[k]) begin
                    if (hits_r[k] > 0) nr[k] = 1;
                    if (hits_r[k] > 1) conf = 1;
                end
                foreach (hits_p[k]) begin
                    if (hits_p[k] > 0) np[k] = 1;
                    if (hits_p[k] > 1) conf = 1;
                end
            end
            case (phase)
                0: phase = drain_req ? 1 : 0;
                1: phase = !drain_req ? 0 : (empty ? 2 : 1);
                default: phase = 0;
            endcase
            m_r = nr;
            m_p = np;
        end
        e.cnt = 0;
        foreach (m_r[k]) begin
            e.r[k] = m_r[k];
            e.cnt  = e.cnt + 6'(m_r[k]);
        end
        foreach (m_p[k]) begin
            e.p[k] = m_p[k];
            e.cnt  = e.cnt + 6'(m_p[k]);
        end
        e.hold = (phase != 0);
        e.ack  = (phase == 2);
        e.conf = conf;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("reg_scoreboard",  reg_sb,            e.r);
                chk("pred_scoreboard", {29'd0, pred_sb},  {29'd0, e.p});
                chk("sb_hold",         {31'd0, sb_hold},  {31'd0, e.hold});
                chk("drain_ack",       {31'd0, drain_ack},{31'd0, e.ack});
                chk("sb_conflict",     {31'd0, conflict}, {31'd0, e.conf});
                chk("sb_pending_cnt",  {26'd0, cnt},      {26'd0, e.cnt});
            end
        end
    end

    task automatic idle();
        rst            = 1'b0;
        issue_valid    = 1'b0;
        issue_rd_we    = '0;
        issue_rd_num   = '0;
        issue_pred_we  = '0;
        issue_pred_num = '0;
        wb_rd_we       = '0;
        wb_rd_num      = '0;
        wb_pred_we     = '0;
        wb_pred_num    = '0;
        pipe_flush     = 1'b0;
        drain_req      = 1'b0;
    endtask

    task automatic nc();
        @(negedge clk);
        idle();
    endtask

    task automatic iss_rd(input int l, input int r);
        issue_valid = 1'b1;
        issue_rd_we[l] = 1'b1;
        issue_rd_num[l*5 +: 5] = 5'(r);
    endtask

    task automatic iss_pr(input int l, input int p);
        issue_valid = 1'b1;
        issue_pred_we[l] = 1'b1;
        issue_pred_num[l*2 +: 2] = 2'(p);
    endtask

    task automatic wbr(input int l, input int r);
        wb_rd_we[l] = 1'b1;
        wb_rd_num[l*5 +: 5] = 5'(r);
    endtask

    task automatic wbp(input int l, input int p);
        wb_pred_we[l] = 1'b1;
        wb_pred_num[l*2 +: 2] = 2'(p);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // reset state
        nc(); rst = 1'b1; model_step();
        nc(); rst = 1'b1; model_step();
        nc(); model_step();

        // lane0 rd=5, lane2 pred=1; then retire both
        nc(); iss_rd(0, 5); iss_pr(2, 1); model_step();
        nc(); wbr(0, 5); wbp(1, 1); model_step();
        nc(); model_step();

        // same-cycle retire and re-issue of r7; duplicate issue of r9
        nc(); iss_rd(0, 7); model_step();
        nc(); iss_rd(1, 7); wbr(2, 7); model_step();
        nc(); iss_rd(1, 9); iss_rd(3, 9); model_step();
        nc(); model_step();
        nc(); wbr(0, 7); wbr(1, 9); model_step();

        // drain with r3 pending: issues ignored, ack after retire
        nc(); iss_rd(0, 3); model_step();
        nc(); drain_req = 1'b1; model_step();
        nc(); drain_req = 1'b1; iss_rd(0, 10); iss_pr(1, 0); model_step();
        nc(); drain_req = 1'b1; model_step();
        nc(); drain_req = 1'b1; wbr(0, 3); model_step();
        nc(); drain_req = 1'b1; model_step();
        nc(); drain_req = 1'b1; model_step();
        nc(); model_step();
        nc(); model_step();

        // empty-scoreboard drain: minimum latency
        repeat (3) begin nc(); drain_req = 1'b1; model_step(); end
        nc(); model_step();

        // drain abandoned when request drops
        nc(); iss_rd(0, 8); model_step();
        repeat (2) begin nc(); drain_req = 1'b1; model_step(); end
        nc(); model_step();
        nc(); wbr(3, 8); model_step();

        // flush while waiting: ack follows
        nc(); iss_rd(2, 11); iss_pr(0, 2); model_step();
        repeat (2) begin nc(); drain_req = 1'b1; model_step(); end
        nc(); drain_req = 1'b1; pipe_flush = 1'b1; model_step();
        repeat (3) begin nc(); drain_req = 1'b1; model_step(); end
        nc(); model_step();

        // 20 pending bits, then flush plus an issue of r1
        for (int c = 0; c < 5; c++) begin
            nc();
            for (int l = 0; l < NL; l++) iss_rd(l, 12 + c*4 + l - 8);
            model_step();
        end
        nc(); pipe_flush = 1'b1; iss_rd(0, 1); wbr(1, 4); model_step();
        nc(); model_step();

        // reset in the middle of a drain with bits pending
        nc(); iss_rd(0, 2); iss_rd(1, 6); iss_pr(2, 0); model_step();
        repeat (2) begin nc(); drain_req = 1'b1; model_step(); end
        nc(); drain_req = 1'b1; rst = 1'b1; wbr(0, 2); model_step();
        nc(); model_step();

        // pred 3 ignored, retire of unset r4 flagged
        nc(); iss_pr(0, 3); wbr(1, 4); wbp(2, 3); model_step();
        nc(); model_step();

        // random traffic
        for (int c = 0; c < 800; c++) begin
            bit dr;
            dr = drain_req;
            nc();
            if ($urandom_range(0, 9) == 0) dr = ~dr;
            drain_req = dr;
            rst = ($urandom_range(0, 199) == 0);
            pipe_flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int l = 0; l < NL; l++) begin
                    if ($urandom_range(0, 9) < 4) iss_rd(l, int'($urandom_range(0, 15)));
                    if ($urandom_range(0, 9) < 3) iss_pr(l, int'($urandom_range(0, 3)));
                end
            end
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(0, 9) < 3) wbr(l, int'($urandom_range(0, 15)));
                if ($urandom_range(0, 9) < 2) wbp(l, int'($urandom_range(0, 3)));
            end
            model_step();
        end

        nc(); model_step();
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcpu_core_scoreboard.md
MCPU_CORE_SCOREBOARD -- requirements
Module: MCPU_CORE_scoreboard

Interface
REQ-001 SHALL have parameter NLANES, default 4, meaning the number of issue/writeback lanes per bundle.
REQ-002 SHALL have port clkrst_core_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clkrst_core_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port issue_valid, input, 1, decode bundle issues this cycle.
REQ-005 SHALL have port issue_rd_we, input, NLANES, per-lane GPR write enable at issue.
REQ-006 SHALL have port issue_rd_num, input, 5*NLANES, per-lane destination GPR; lane i is bits [5i+4:5i].
REQ-007 SHALL have port issue_pred_we, input, NLANES, per-lane predicate write enable at issue.
REQ-008 SHALL have port issue_pred_num, input, 2*NLANES, per-lane destination predicate.
REQ-009 SHALL have ports wb_rd_we, wb_rd_num, wb_pred_we, wb_pred_num, inputs, same widths as the issue_* ports, per-lane writeback retire.
REQ-010 SHALL have port pipe_flush, input, 1, squash all in-flight writes.
REQ-011 SHALL have port drain_req, input, 1, request to wait until no writes are pending (fence/eret/mtc).
REQ-012 SHALL have port sb2d_reg_scoreboard, output, 32, pending-GPR-write bits to decode.
REQ-013 SHALL have port sb2d_pred_scoreboard, output, 3, pending-write bits for p0..p2.
REQ-014 SHALL have port sb_hold, output, 1, blocks decode issue while draining.
REQ-015 SHALL have port drain_ack, output, 1, one-cycle drain-complete pulse.
REQ-016 SHALL have port sb_pending_cnt, output, 6, count of set scoreboard bits (0..35).
REQ-017 SHALL have port sb_conflict, output, 1, one-cycle pulse on an illegal issue or writeback event.

Function
REQ-018 SHALL hold all outputs in registers; an issue or writeback in cycle N becomes visible in cycle N+1.
REQ-019 SHALL set reg bit r in N+1 when issue_valid=1 and some lane has issue_rd_we=1 with issue_rd_num=r in cycle N.
REQ-020 SHALL set pred bit p in N+1 when issue_valid=1 and some lane has issue_pred_we=1 with issue_pred_num=p, p<3.
REQ-021 SHALL ignore predicate number 3 (always-true) on both issue and writeback.
REQ-022 SHALL ignore all issue_* inputs while issue_valid=0 or sb_hold=1.
REQ-023 SHALL clear reg/pred bit x in N+1 when any lane presents wb_*_we=1 for x in cycle N; wb inputs need no issue_valid.
REQ-024 SHALL let the set win when the same bit is both issued and retired in one cycle (bit remains 1).
REQ-025 SHALL pulse sb_conflict for one cycle in N+1 if two lanes issue the same GPR or same predicate (p<3) in cycle N, or if a lane retires a bit that is 0; the state update still applies.
REQ-026 SHALL, on pipe_flush=1 in cycle N, clear all 35 bits in N+1, ignoring issue and writeback that cycle, with no sb_conflict pulse.
REQ-027 SHALL compute sb_pending_cnt as the popcount of the next-state reg and pred bits, so it always matches the visible bits.
REQ-028 SHALL implement drain FSM states IDLE, WAIT, ACK.
REQ-029 SHALL move IDLE->WAIT when drain_req=1; sb_hold=1 in WAIT.
REQ-030 SHALL move WAIT->ACK when all registered bits are 0; drain_ack=1 and sb_hold=1 in ACK; ACK->IDLE unconditionally the next cycle.
REQ-031 SHALL move WAIT->IDLE with no ack if drain_req drops before completion.
REQ-032 SHALL enter ACK one cycle after a flush in WAIT, since all bits are 0 by then.
REQ-033 SHALL move IDLE->WAIT->ACK on back-to-back cycles for drain_req with an empty scoreboard (2-cycle min latency, request to ack).

Reset
REQ-034 SHALL, when clkrst_core_rst=1 at a clock edge, clear all bits, sb_pending_cnt=0, sb_hold=0, drain_ack=0, sb_conflict=0, FSM=IDLE.
REQ-035 SHALL give reset priority over flush, issue, writeback and drain, including mid-drain (no ack issued).

Verification
REQ-036 SHALL cover: issue lane0 rd=5, lane2 pred=1 -> next cycle reg bit5=1, pred bit1=1, cnt=2; retire both -> bits 0, cnt=0.
REQ-037 SHALL cover: same-cycle retire and re-issue of r7 -> bit7 stays 1; lanes 1 and 3 both issue r9 -> bit9=1, sb_conflict pulses once.
REQ-038 SHALL cover: drain_req with r3 pending -> sb_hold=1 and issues ignored; retire r3 -> drain_ack 1 cycle later, single pulse.
REQ-039 SHALL cover: 20 bits pending, pipe_flush plus an issue of r1 -> all bits 0, cnt=0, no conflict.
REQ-040 SHALL cover: reset asserted while in WAIT with bits pending -> all outputs 0, FSM IDLE, no drain_ack.
REQ-041 SHALL cover: issue pred 3 and retire unset r4 -> pred scoreboard unchanged; sb_conflict pulses for r4 only.
